regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
Write-back scheduler in front of the 32x32 register file (single write port: RegWrite/WR/WD). It shares that port between two write-back sources, A (ALU) and B (load/multicycle unit). Each source uses a valid/ready handshake. It also keeps a per-register pending-write scoreboard so issue logic can detect RAW and WAW hazards. It sits between the execute/memory stages and the register file; x0 is never written.

Parameters:
NREG, 32, number of architectural registers
AW, 5, register index width
DW, 32, data width
PRIO_MODE, 0, 0 = round-robin between A and B; 1 = fixed priority, A always wins

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
iss_valid  in  1  instruction issuing this cycle that will write iss_rd
iss_rd  in  AW  destination register of issuing instruction
iss_ready  out  1  issue allowed (no WAW on iss_rd)
rs1  in  AW  source register 1 of the instruction in decode
rs2  in  AW  source register 2 of the instruction in decode
rs1_busy  out  1  rs1 has a pending write (RAW stall)
rs2_busy  out  1  rs2 has a pending write (RAW stall)
a_valid  in  1  source A write-back request
a_rd  in  AW  source A destination
a_data  in  DW  source A data
a_ready  out  1  source A request accepted this cycle
b_valid  in  1  source B write-back request
b_rd  in  AW  source B destination
b_data  in  DW  source B data
b_ready  out  1  source B request accepted this cycle
RegWrite  out  1  register file write enable
WR  out  AW  register file write index
WD  out  DW  register file write data
busy_vec  out  NREG  scoreboard state, bit r = register r pending
wb_err  out  1  sticky: write-back to a register that was not pending

Behaviour:
- Reset (rst_n low, async): RegWrite=0, WR=0, WD=0, busy_vec=0, wb_err=0, round-robin pointer favours A. In-flight requests are dropped; sources must re-present after reset.
- Arbitration is combinational; a_ready/b_ready are the grants. At most one is high per cycle. The output stage never stalls, so one write-back is accepted every cycle.
- Only A valid -> A granted. Only B valid -> B granted.
- Both valid, PRIO_MODE=1 -> A granted.
- Both valid, PRIO_MODE=0 -> grant the source not granted on the most recent conflict. The pointer updates only on cycles where both are valid.
- Output register, latency 1: a grant at edge t drives WR/WD from the winner during cycle t..t+1. RegWrite=1 in that cycle only when the winner's rd != 0; otherwise RegWrite=0.
- The register file captures at the next edge. With no grant, RegWrite=0 and WR/WD hold their last value.
- A grant with rd=0 is consumed (ready=1) but never written and never sets wb_err.
- Scoreboard set: on an edge with iss_valid && iss_ready && iss_rd != 0, set busy[iss_rd].
- Scoreboard clear: on an edge where RegWrite=1, clear busy[WR]. This coincides with the register file capturing WD.
- If set and clear hit the same register on the same edge, set wins. This is reachable only after a WAW-free issue races a stale write-back, and it is flagged via wb_err.
- iss_ready = (iss_rd == 0) || !busy[iss_rd]. It depends only on registered busy, with no same-cycle clear bypass.
- rs1_busy = (rs1 != 0) && busy[rs1], same for rs2. Purely combinational from registered busy. No data forwarding is provided.
- wb_err is set on the edge where a grant with rd != 0 targets a register whose busy bit is 0. It clears only on reset.
- A/B requests must hold valid, rd and data stable until ready. The arbiter does not check this.

Decomposition:
- Package regfile_pkg holds: NREG, AW, DW, PRIO_RR=0, PRIO_FIXED=1, and the write-back request struct {valid, rd, data}.
- Sub-module rr_arbiter2: two-requester arbiter with mode input, grant outputs and the conflict pointer.
- Scoreboard and output register stay in the top module.

Test Plan:
- Reset then idle -> RegWrite=0, WR=0, WD=0, busy_vec=0, iss_ready=1 for any rd, wb_err=0.
- Issue rd=5, then A writes rd=5 data 0xDEADBEEF two cycles later -> busy_vec[5]=1 and rs1_busy=1 while pending; RegWrite=1, WR=5, WD=0xDEADBEEF one cycle after a_ready; busy_vec[5]=0 the following cycle.
- Issue rd=7, then re-issue rd=7 -> second iss_ready=0 until the write-back to 7 commits; rd=0 issue always ready and never sets busy.
- PRIO_MODE=0, A and B both valid (rd 3/4, 4 consecutive cycles with new data each grant) -> grants A,B,A,B; PRIO_MODE=1 -> A,A,A,A and b_ready=0 throughout.
- A write-back rd=0 data 0x1234 -> a_ready=1, RegWrite stays 0, wb_err stays 0; B write-back rd=9 with busy[9]=0 -> write occurs and wb_err=1 sticky.
- Assert rst_n low mid-cycle while busy_vec=0x0000_0120 and RegWrite=1 -> outputs clear immediately without waiting for a clock edge, busy_vec=0, RegWrite=0.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file write-back scheduler.
package regfile_pkg;
    localparam int NREG       = 32;
    localparam int AW         = 5;
    localparam int DW         = 32;
    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wb_req_t;

    // Conflict pointer: which source wins the next A/B collision.
    typedef enum logic {
        FAVOR_A = 1'b0,
        FAVOR_B = 1'b1
    } rr_state_t;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-requester arbiter: round-robin on collisions, or fixed priority to A.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic fixed_prio,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);
    rr_state_t state, state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FAVOR_A;
        else        state <= state_nxt;
    end

    // The pointer only moves on a real collision, so lone requests never skew fairness.
    always_comb begin
        gnt_a     = 1'b0;
        gnt_b     = 1'b0;
        state_nxt = state;
        if (req_a && req_b) begin
            if (fixed_prio) begin
                gnt_a = 1'b1;
            end else if (state == FAVOR_A) begin
                gnt_a     = 1'b1;
                state_nxt = FAVOR_B;
            end else begin
                gnt_b     = 1'b1;
                state_nxt = FAVOR_A;
            end
        end else begin
            gnt_a = req_a;
            gnt_b = req_b;
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back scheduler sharing the register-file write port between two sources,
// with a pending-write scoreboard for RAW/WAW hazard detection.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int PRIO_MODE = PRIO_RR
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    output logic            iss_ready,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            a_valid,
    input  logic [AW-1:0]   a_rd,
    input  logic [DW-1:0]   a_data,
    output logic            a_ready,
    input  logic            b_valid,
    input  logic [AW-1:0]   b_rd,
    input  logic [DW-1:0]   b_data,
    output logic            b_ready,
    output logic            RegWrite,
    output logic [AW-1:0]   WR,
    output logic [DW-1:0]   WD,
    output logic [NREG-1:0] busy_vec,
    output logic            wb_err
);
    wb_req_t         a_req, b_req, win;
    logic            gnt_a, gnt_b;
    logic [NREG-1:0] busy, busy_nxt;

    assign a_req = '{valid: a_valid, rd: a_rd, data: a_data};
    assign b_req = '{valid: b_valid, rd: b_rd, data: b_data};

    rr_arbiter2 u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .fixed_prio (PRIO_MODE == PRIO_FIXED),
        .req_a      (a_valid),
        .req_b      (b_valid),
        .gnt_a      (gnt_a),
        .gnt_b      (gnt_b)
    );

    assign a_ready = gnt_a;
    assign b_ready = gnt_b;

    always_comb begin
        win = '0;
        if (gnt_a)      win = a_req;
        else if (gnt_b) win = b_req;
    end

    // Hazard views use registered busy only; a commit this cycle is not bypassed.
    assign iss_ready = (iss_rd == '0) || !busy[iss_rd];
    assign rs1_busy  = (rs1 != '0) && busy[rs1];
    assign rs2_busy  = (rs2 != '0) && busy[rs2];
    assign busy_vec  = busy;

    // Set is applied after clear so a same-edge race leaves the register pending.
    always_comb begin
        busy_nxt = busy;
        if (RegWrite) busy_nxt[WR] = 1'b0;
        if (iss_valid && iss_ready && (iss_rd != '0)) busy_nxt[iss_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWrite <= 1'b0;
            WR       <= '0;
            WD       <= '0;
            busy     <= '0;
            wb_err   <= 1'b0;
        end else begin
            busy     <= busy_nxt;
            RegWrite <= win.valid && (win.rd != '0);
            if (win.valid) begin
                WR <= win.rd;
                WD <= win.data;
            end
            if (win.valid && (win.rd != '0) && !busy[win.rd]) wb_err <= 1'b1;
        end
    end
endmodule
